// File: rtl/serial_window_builder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_window_builder_pkg
//  Description : Shared window width, fill-state encoding and fill-step helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_window_builder_pkg;

    localparam int WIN_W = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        FULL  = 2'd3
    } state_t;

    // One accepted bit advances the fill level; FULL is absorbing.
    function automatic state_t next_fill(input state_t s);
        case (s)
            EMPTY:   next_fill = FILL1;
            FILL1:   next_fill = FILL2;
            default: next_fill = FULL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_window_builder_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_window_builder_if
//  Description : Serial bit input and 3-bit window / palindrome status bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_window_builder_if #(
    parameter int CNT_W = 8
);

    logic             bit_in;
    logic             bit_valid;
    logic             clear;
    logic             win_a;
    logic             win_b;
    logic             win_c;
    logic             win_valid;
    logic             pal_flag;
    logic [CNT_W-1:0] pal_count;

    modport master (
        output bit_in, bit_valid, clear,
        input  win_a, win_b, win_c, win_valid, pal_flag, pal_count
    );

    modport slave (
        input  bit_in, bit_valid, clear,
        output win_a, win_b, win_c, win_valid, pal_flag, pal_count
    );

endinterface
`default_nettype wire

// File: rtl/serial_window_builder_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones; clear beats increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         clr,
    input  wire logic         inc,
    output logic      [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/serial_window_builder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_window_builder
//  Description : Serial-to-3-bit sliding window with fill tracking, registered
//                palindrome flag and saturating palindrome-window count.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_window_builder
    import serial_window_builder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    serial_window_builder_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIN_W-1:0] r_win;
    logic [WIN_W-1:0] w_win_next;
    logic             r_pal_flag;
    logic             w_pal_next;
    logic             w_pal_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_win      <= '0;
            r_pal_flag <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_win      <= w_win_next;
            r_pal_flag <= w_pal_next;
        end
    end

    // r_win[2] is the oldest bit, r_win[0] the newest; flag uses the post-shift window.
    always_comb begin
        w_state_next = r_state;
        w_win_next   = r_win;
        w_pal_next   = r_pal_flag;
        w_pal_inc    = 1'b0;
        if (bus.clear) begin
            w_state_next = EMPTY;
            w_win_next   = '0;
            w_pal_next   = 1'b0;
        end else if (bus.bit_valid) begin
            w_state_next = next_fill(r_state);
            w_win_next   = {r_win[WIN_W-2:0], bus.bit_in};
            w_pal_next   = (w_state_next == FULL) && (w_win_next[WIN_W-1] == w_win_next[0]);
            w_pal_inc    = w_pal_next;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_pal_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clear),
        .inc   (w_pal_inc),
        .count (bus.pal_count)
    );

    assign bus.win_a     = r_win[2];
    assign bus.win_b     = r_win[1];
    assign bus.win_c     = r_win[0];
    assign bus.win_valid = (r_state == FULL);
    assign bus.pal_flag  = r_pal_flag;

endmodule
`default_nettype wire
